multi_digit_counter: RTL and testbench

//   Parametrised multi-digit modulo-N counter: DIGITS cascaded digits, each counting 0..MODULUS-1.

---
 rtl/multi_digit_counter_pkg.sv | 13 +
 rtl/mod_n_digit.sv | 42 ++++
 rtl/multi_digit_counter.sv | 72 +++++++
 tb/tb_multi_digit_counter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/multi_digit_counter_pkg.sv
// Shared types and helpers for the multi-digit modulo-N counter.
package multi_digit_counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  function automatic int unsigned digit_width(input int unsigned modulus);
    return (modulus < 2) ? 1 : $clog2(modulus);
  endfunction

endpackage

// File: rtl/mod_n_digit.sv
// One modulo-N digit: clear > load (clamped) > step > hold.
module mod_n_digit
  import multi_digit_counter_pkg::*;
#(
  parameter  int unsigned MODULUS = 10,
  localparam int unsigned DW      = digit_width(MODULUS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step,
  input  dir_e          up,
  input  logic          clr,
  input  logic          load,
  input  logic [DW-1:0] load_val,
  output logic [DW-1:0] digit,
  output logic          is_max,
  output logic          is_zero
);

  localparam logic [DW-1:0] MAXV = DW'(MODULUS - 1);

  logic [DW-1:0] ld_clamped;
  logic [DW-1:0] stepped;

  assign is_max  = (digit == MAXV);
  assign is_zero = (digit == '0);

  always_comb begin
    ld_clamped = (load_val > MAXV) ? MAXV : load_val;
    stepped    = digit;
    if (up == DIR_UP) stepped = is_max  ? '0   : digit + 1'b1;
    else              stepped = is_zero ? MAXV : digit - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     digit <= '0;
    else if (clr)   digit <= '0;
    else if (load)  digit <= ld_clamped;
    else if (step)  digit <= stepped;
  end

endmodule

// File: rtl/multi_digit_counter.sv
// Cascaded DIGITS x modulo-MODULUS up/down counter with carry/borrow output.
// Define MULTI_DIGIT_COUNTER_SAT_EN to saturate at all-max/all-zero instead of wrapping.
module multi_digit_counter
  import multi_digit_counter_pkg::*;
#(
  parameter  int unsigned DIGITS  = 4,
  parameter  int unsigned MODULUS = 10,
  localparam int unsigned DW      = digit_width(MODULUS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 up,
  input  logic                 clr,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_val,
  output logic [DIGITS*DW-1:0] count,
  output logic                 carry_out,
  output logic                 at_max,
  output logic                 at_zero
);

  dir_e              dir;
  logic [DIGITS-1:0] is_max;
  logic [DIGITS-1:0] is_zero;
  logic [DIGITS-1:0] ripple;
  logic [DIGITS-1:0] step;
  logic              terminal;
  logic              en_eff;
  logic              acc;

  assign dir     = up ? DIR_UP : DIR_DOWN;
  assign at_max  = &is_max;
  assign at_zero = &is_zero;

  always_comb begin
    terminal = (dir == DIR_UP) ? at_max : at_zero;
`ifdef MULTI_DIGIT_COUNTER_SAT_EN
    en_eff    = en & ~terminal;
    carry_out = 1'b0;
`else
    en_eff    = en;
    carry_out = rst_n & en & ~clr & ~load & terminal;
`endif
    ripple = (dir == DIR_UP) ? is_max : is_zero;
    step   = '0;
    // running AND keeps the ripple chain free of self-referencing vector bits
    acc    = en_eff;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      step[i] = acc;
      acc     = acc & ripple[i];
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    mod_n_digit #(
      .MODULUS (MODULUS)
    ) u_digit (
      .clk      (clk),
      .rst_n    (rst_n),
      .step     (step[g]),
      .up       (dir),
      .clr      (clr),
      .load     (load),
      .load_val (load_val[g*DW +: DW]),
      .digit    (count[g*DW +: DW]),
      .is_max   (is_max[g]),
      .is_zero  (is_zero[g])
    );
  end

endmodule

// File: tb/tb_multi_digit_counter.sv
// Directed bench for multi_digit_counter (2x mod-10 default; 3x mod-6 when saturating).
module tb_multi_digit_counter;
  import multi_digit_counter_pkg::*;

`ifdef MULTI_DIGIT_COUNTER_SAT_EN
  localparam int unsigned DIGITS  = 3;
  localparam int unsigned MODULUS = 6;
`else
  localparam int unsigned DIGITS  = 2;
  localparam int unsigned MODULUS = 10;
`endif
  localparam int unsigned DW = digit_width(MODULUS);
  localparam int unsigned W  = DIGITS * DW;

  logic         clk = 1'b0;
  logic         rst_n, en, up, clr, load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         carry_out, at_max, at_zero;

  int errors = 0;
  int checks = 0;

  multi_digit_counter #(
    .DIGITS  (DIGITS),
    .MODULUS (MODULUS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .up        (up),
    .clr       (clr),
    .load      (load),
    .load_val  (load_val),
    .count     (count),
    .carry_out (carry_out),
    .at_max    (at_max),
    .at_zero   (at_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic         clr, load, en, up;
    logic [W-1:0] lv;
    logic         carry;   // expected before the edge
    logic [W-1:0] exp;     // expected after the edge
    logic         mx, zr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: act=%0h req=%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic c, input logic l, input logic e, input logic u,
                       input logic [W-1:0] v);
    @(negedge clk);
    clr = c; load = l; en = e; up = u; load_val = v;
  endtask

  task automatic add(input logic c, input logic l, input logic e, input logic u,
                     input logic [W-1:0] v, input logic cy, input logic [W-1:0] x,
                     input logic m, input logic z);
    vec_t t;
    t.clr = c; t.load = l; t.en = e; t.up = u; t.lv = v;
    t.carry = cy; t.exp = x; t.mx = m; t.zr = z;
    vecs.push_back(t);
  endtask

  function automatic logic [W-1:0] pk(input int unsigned d2, input int unsigned d1,
                                      input int unsigned d0);
    logic [W-1:0] r;
    r = '0;
    r[0 +: DW] = DW'(d0);
    if (DIGITS > 1) r[DW +: DW] = DW'(d1);
    if (DIGITS > 2) r[2*DW +: DW] = DW'(d2);
    return r;
  endfunction

  initial begin
    rst_n = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
    #3;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_zero", 32'(at_zero), 32'd1);
    chk("reset_max", 32'(at_max), 32'd0);
    chk("reset_carry", 32'(carry_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef MULTI_DIGIT_COUNTER_SAT_EN
    // one step below all-max, then up into saturation
    drive(0, 1, 0, 1, pk(5, 5, 4));
    @(posedge clk); #1;
    chk("sat_load_554", 32'(count), 32'(pk(5, 5, 4)));
    drive(0, 0, 1, 1, '0);
    #1 chk("sat_carry_pre", 32'(carry_out), 32'd0);
    @(posedge clk); #1;
    chk("sat_step_555", 32'(count), 32'(pk(5, 5, 5)));
    chk("sat_at_max", 32'(at_max), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("sat_hold_carry", 32'(carry_out), 32'd0);
      @(posedge clk); #1;
      chk("sat_hold_555", 32'(count), 32'(pk(5, 5, 5)));
    end
    drive(0, 0, 1, 0, '0);
    @(posedge clk); #1;
    chk("sat_down_554", 32'(count), 32'(pk(5, 5, 4)));
    drive(1, 0, 0, 0, '0);
    @(posedge clk); #1;
    chk("sat_clr", 32'(count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, '0);
      #1 chk("sat_zero_carry", 32'(carry_out), 32'd0);
      @(posedge clk); #1;
      chk("sat_zero_hold", 32'(count), 32'd0);
    end
    chk("sat_at_zero", 32'(at_zero), 32'd1);
`else
    //  clr load en up  lv      carry  exp    mx zr
    add(0,  1,   0, 1, 8'h47,  0,     8'h47, 0, 0);
    add(0,  1,   0, 1, 8'hFA,  0,     8'h99, 1, 0);
    add(1,  1,   1, 1, 8'h12,  0,     8'h00, 0, 1);
    add(0,  0,   1, 1, 8'h00,  0,     8'h01, 0, 0);
    add(0,  1,   0, 1, 8'hA5,  0,     8'h95, 0, 0);
    add(0,  0,   1, 0, 8'h00,  0,     8'h94, 0, 0);
    add(0,  1,   0, 1, 8'h25,  0,     8'h25, 0, 0);
    add(0,  0,   0, 1, 8'h00,  0,     8'h25, 0, 0);
    add(0,  0,   0, 0, 8'h00,  0,     8'h25, 0, 0);
    add(0,  0,   0, 1, 8'h00,  0,     8'h25, 0, 0);
    add(0,  0,   1, 1, 8'h00,  0,     8'h26, 0, 0);
    add(0,  0,   1, 0, 8'h00,  0,     8'h25, 0, 0);
    add(0,  0,   1, 1, 8'h00,  0,     8'h26, 0, 0);
    add(0,  1,   1, 1, 8'h09,  0,     8'h09, 0, 0);
    add(0,  0,   1, 1, 8'h00,  0,     8'h10, 0, 0);
    add(0,  0,   1, 0, 8'h00,  0,     8'h09, 0, 0);
    add(0,  1,   0, 1, 8'h99,  0,     8'h99, 1, 0);
    add(0,  0,   1, 1, 8'h00,  1,     8'h00, 0, 1);
    add(0,  0,   1, 0, 8'h00,  1,     8'h99, 1, 0);
    add(0,  1,   1, 1, 8'h00,  0,     8'h00, 0, 1);
    add(0,  0,   1, 0, 8'h00,  1,     8'h99, 1, 0);

    foreach (vecs[k]) begin
      drive(vecs[k].clr, vecs[k].load, vecs[k].en, vecs[k].up, vecs[k].lv);
      #1 chk($sformatf("vec%0d_carry", k), 32'(carry_out), 32'(vecs[k].carry));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_count", k), 32'(count), 32'(vecs[k].exp));
      chk($sformatf("vec%0d_max", k), 32'(at_max), 32'(vecs[k].mx));
      chk($sformatf("vec%0d_zero", k), 32'(at_zero), 32'(vecs[k].zr));
    end

    // asynchronous reset mid-count, away from any edge
    drive(0, 1, 0, 1, 8'h37);
    @(posedge clk); #1;
    chk("pre_rst_37", 32'(count), 32'h37);
    en = 1'b1; up = 1'b0; load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 32'h00);
    chk("async_rst_zero", 32'(at_zero), 32'd1);
    chk("async_rst_carry", 32'(carry_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0;

    // full up wrap
    drive(1, 0, 0, 1, '0);
    @(posedge clk); #1;
    drive(0, 0, 1, 1, '0);
    for (int i = 0; i < 99; i++) @(posedge clk);
    #1;
    chk("up99_count", 32'(count), 32'h99);
    chk("up99_max", 32'(at_max), 32'd1);
    chk("up99_carry", 32'(carry_out), 32'd1);
    @(posedge clk); #1;
    chk("up100_count", 32'(count), 32'h00);
    chk("up100_carry", 32'(carry_out), 32'd0);

    // borrow from zero, then ten down steps
    drive(0, 0, 1, 0, '0);
    #1 chk("down_borrow", 32'(carry_out), 32'd1);
    @(posedge clk); #1;
    chk("down_wrap_99", 32'(count), 32'h99);
    for (int i = 0; i < 10; i++) @(posedge clk);
    #1;
    chk("down10_89", 32'(count), 32'h89);
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
